// File: rtl/accum_core_pkg.sv
// Shared definitions for the accumulator core: opcode encoding, FSM states
// and the opcode field width.
package accum_core_pkg;

    localparam int OPCODE_W = 4;

    typedef enum logic [OPCODE_W-1:0] {
        OP_NOP = 4'h0,
        OP_IN  = 4'h1,
        OP_OUT = 4'h2,
        OP_LD  = 4'h3,
        OP_ST  = 4'h4,
        OP_ADD = 4'h5,
        OP_SUB = 4'h6,
        OP_AND = 4'h7,
        OP_OR  = 4'h8,
        OP_XOR = 4'h9,
        OP_NOT = 4'hA,
        OP_SHL = 4'hB,
        OP_SHR = 4'hC,
        OP_MUL = 4'hD,
        OP_CLR = 4'hE,
        OP_ILL = 4'hF
    } opcode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_e;

endpackage

// File: rtl/accum_alu.sv
// Combinational ALU for the arithmetic, logic and shift opcodes.
// Opcodes outside that group pass the accumulator and carry through untouched.
module accum_alu
    import accum_core_pkg::*;
#(
    parameter int DATA_W = 4
) (
    input  opcode_e           op_i,
    input  logic [DATA_W-1:0] acc_i,
    input  logic [DATA_W-1:0] opnd_i,
    input  logic              carry_i,
    output logic [DATA_W-1:0] res_o,
    output logic              carry_o
);

    logic [DATA_W:0] sum_w;
    logic [DATA_W:0] diff_w;

    // The extra top bit of the difference is the borrow.
    assign sum_w  = {1'b0, acc_i} + {1'b0, opnd_i};
    assign diff_w = {1'b0, acc_i} - {1'b0, opnd_i};

    // Result/carry select; logic ops keep the incoming carry.
    always_comb begin
        res_o   = acc_i;
        carry_o = carry_i;
        case (op_i)
            OP_ADD: begin
                res_o   = sum_w[DATA_W-1:0];
                carry_o = sum_w[DATA_W];
            end
            OP_SUB: begin
                res_o   = diff_w[DATA_W-1:0];
                carry_o = diff_w[DATA_W];
            end
            OP_AND: res_o = acc_i & opnd_i;
            OP_OR:  res_o = acc_i | opnd_i;
            OP_XOR: res_o = acc_i ^ opnd_i;
            OP_NOT: res_o = ~acc_i;
            OP_SHL: begin
                res_o   = {acc_i[DATA_W-2:0], 1'b0};
                carry_o = acc_i[DATA_W-1];
            end
            OP_SHR: begin
                res_o   = {1'b0, acc_i[DATA_W-1:1]};
                carry_o = acc_i[0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/accum_core.sv
// Accumulator processor core with register file, carry/zero flags, output
// strobe and illegal-opcode pulse. Defining ACCUM_CORE_MUL_EN adds an
// iterative shift-add multiplier (opcode MUL); otherwise MUL is illegal.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | ready for an instruction; single-cycle ops complete here
// ST_MUL  | multiplier stepping, one partial product per cycle, not ready
module accum_core
    import accum_core_pkg::*;
#(
    parameter int DATA_W   = 4,
    parameter int NUM_REGS = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [OPCODE_W+$clog2(NUM_REGS)-1:0] instr,
    input  logic                               instr_valid,
    output logic                               instr_ready,
    input  logic [DATA_W-1:0]                  portin,
    output logic [DATA_W-1:0]                  portout,
    output logic                               portout_valid,
    output logic                               zero,
    output logic                               carry,
    output logic                               illegal
);

    localparam int REG_AW = $clog2(NUM_REGS);

    state_e                           state_q, state_d;
    logic [DATA_W-1:0]                acc_q, acc_d;
    logic                             carry_q, carry_d;
    logic [NUM_REGS-1:0][DATA_W-1:0]  regs_q, regs_d;
    logic [DATA_W-1:0]                portout_q, portout_d;
    logic                             pv_q, pv_d;
    logic                             ill_q, ill_d;

    opcode_e           op_w;
    logic [REG_AW-1:0] idx_w;
    logic [DATA_W-1:0] opnd_w;
    logic              accept_w;
    logic [DATA_W-1:0] alu_res_w;
    logic              alu_carry_w;

    assign op_w     = opcode_e'(instr[OPCODE_W-1:0]);
    assign idx_w    = instr[OPCODE_W+REG_AW-1:OPCODE_W];
    assign opnd_w   = regs_q[idx_w];
    assign accept_w = instr_valid && (state_q == ST_IDLE);

`ifdef ACCUM_CORE_MUL_EN
    localparam int CNT_W = $clog2(DATA_W + 1);

    // Full-width product so the upper half can drive the overflow carry.
    logic [2*DATA_W-1:0] prod_q, prod_d;
    logic [2*DATA_W-1:0] mcand_q, mcand_d;
    logic [DATA_W-1:0]   mplier_q, mplier_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2*DATA_W-1:0] step_w;

    assign step_w = prod_q + (mplier_q[0] ? mcand_q : '0);
`endif

    accum_alu #(.DATA_W(DATA_W)) u_alu (
        .op_i    (op_w),
        .acc_i   (acc_q),
        .opnd_i  (opnd_w),
        .carry_i (carry_q),
        .res_o   (alu_res_w),
        .carry_o (alu_carry_w)
    );

    // Next-state and datapath decode; every target holds unless an op moves it.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        carry_d   = carry_q;
        regs_d    = regs_q;
        portout_d = portout_q;
        pv_d      = 1'b0;
        ill_d     = 1'b0;
`ifdef ACCUM_CORE_MUL_EN
        prod_d    = prod_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        cnt_d     = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept_w) begin
                    case (op_w)
                        OP_NOP: ;
                        OP_IN:  acc_d = portin;
                        OP_OUT: begin
                            portout_d = acc_q;
                            pv_d      = 1'b1;
                        end
                        OP_LD:  acc_d = opnd_w;
                        OP_ST:  regs_d[idx_w] = acc_q;
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
                        OP_NOT, OP_SHL, OP_SHR: begin
                            acc_d   = alu_res_w;
                            carry_d = alu_carry_w;
                        end
`ifdef ACCUM_CORE_MUL_EN
                        OP_MUL: begin
                            prod_d   = '0;
                            mcand_d  = {{DATA_W{1'b0}}, acc_q};
                            mplier_d = opnd_w;
                            cnt_d    = CNT_W'(DATA_W);
                            state_d  = ST_MUL;
                        end
`endif
                        OP_CLR: begin
                            acc_d   = '0;
                            carry_d = 1'b0;
                        end
                        default: ill_d = 1'b1;
                    endcase
                end
            end
            ST_MUL: begin
`ifdef ACCUM_CORE_MUL_EN
                prod_d   = step_w;
                mcand_d  = {mcand_q[2*DATA_W-2:0], 1'b0};
                mplier_d = {1'b0, mplier_q[DATA_W-1:1]};
                cnt_d    = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    acc_d   = step_w[DATA_W-1:0];
                    carry_d = |step_w[2*DATA_W-1:DATA_W];
                    state_d = ST_IDLE;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Register update; reset also discards any multiply in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            acc_q     <= '0;
            carry_q   <= 1'b0;
            regs_q    <= '0;
            portout_q <= '0;
            pv_q      <= 1'b0;
            ill_q     <= 1'b0;
`ifdef ACCUM_CORE_MUL_EN
            prod_q    <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            carry_q   <= carry_d;
            regs_q    <= regs_d;
            portout_q <= portout_d;
            pv_q      <= pv_d;
            ill_q     <= ill_d;
`ifdef ACCUM_CORE_MUL_EN
            prod_q    <= prod_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign instr_ready   = (state_q == ST_IDLE);
    assign portout       = portout_q;
    assign portout_valid = pv_q;
    assign zero          = (acc_q == '0);
    assign carry         = carry_q;
    assign illegal       = ill_q;

endmodule
